mp64_sim_mem_phy: RTL and testbench

MP64_SIM_MEM_PHY -- requirements
Module: mp64_sim_mem_phy

---
 rtl/mp64_sim_mem_phy.sv | 140 ++++++++++++++
 tb/tb_mp64_sim_mem_phy.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp64_sim_mem_phy.sv
// Behavioural external-memory PHY for simulation: a word-addressed storage array
// serving fixed-latency read bursts and back-pressure-free write bursts on the phy_* stream.
module mp64_sim_mem_phy #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 32,
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phy_req,
    input  logic [ADDR_W-1:0] phy_addr,
    input  logic              phy_wen,
    input  logic [DATA_W-1:0] phy_wdata,
    input  logic [7:0]        phy_burst_len,
    output logic              phy_ready,
    output logic [DATA_W-1:0] phy_rdata,
    output logic              phy_rvalid
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         beats_q, beats_d;
    logic [7:0]         lat_q, lat_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [IDX_W-1:0]   acc_idx;
    logic [7:0]         acc_len;
    logic [DATA_W-1:0]  mem [DEPTH_WORDS] = '{default: '0};

    // Only the word-index slice of the byte address matters; the rest wraps away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{phy_addr[2:0], phy_addr[ADDR_W-1:3+IDX_W]};

    assign acc_idx    = phy_addr[3 +: IDX_W];
    assign acc_len    = (phy_burst_len == 8'd0) ? 8'd1 : phy_burst_len;
    assign phy_ready  = !rst && (state_q == ST_IDLE || state_q == ST_WR);
    assign phy_rvalid = rvalid_q;
    assign phy_rdata  = rdata_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        beats_d  = beats_q;
        lat_d    = lat_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        mem_we   = 1'b0;
        mem_widx = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (phy_req) begin
                    if (phy_wen) begin
                        mem_we   = 1'b1;
                        mem_widx = acc_idx;
                        idx_d    = acc_idx + 1'b1;
                        beats_d  = acc_len - 8'd1;
                        state_d  = (acc_len > 8'd1) ? ST_WR : ST_IDLE;
                    end else begin
                        idx_d    = acc_idx;
                        beats_d  = acc_len;
                        lat_d    = 8'(READ_LATENCY - 1);
                        state_d  = ST_RD_WAIT;
                    end
                end
            end
            ST_WR: begin
                if (phy_req) begin
                    mem_we  = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    beats_d = beats_q - 8'd1;
                    if (beats_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                // The counter reaching zero means this edge launches beat 0.
                if (lat_q == 8'd0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem[idx_q];
                    idx_d    = idx_q + 1'b1;
                    beats_d  = beats_q - 8'd1;
                    state_d  = ST_RD_DATA;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            ST_RD_DATA: begin
                if (beats_q != 8'd0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem[idx_q];
                    idx_d    = idx_q + 1'b1;
                    beats_d  = beats_q - 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            beats_q  <= '0;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            beats_q  <= beats_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage survives reset; only the write strobe is blocked while it is asserted.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_widx] <= phy_wdata;
        end
    end

endmodule

// File: tb/tb_mp64_sim_mem_phy.sv
// Randomised and directed bench for mp64_sim_mem_phy, compared every cycle against
// a transaction-level model of accepts, stored words and scheduled read beats.
module tb_mp64_sim_mem_phy;

    localparam int LAT   = 4;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_r = 1'b1, req_r = 1'b0, wen_r = 1'b0;
    logic [31:0] addr_r = '0;
    logic [63:0] wdata_r = '0;
    logic [7:0]  len_r = '0;
    logic        dut_ready, dut_rvalid;
    logic [63:0] dut_rdata;

    logic        r1_rst = 1'b1, r1_req = 1'b0, r1_wen = 1'b0;
    logic [31:0] r1_addr = '0;
    logic [63:0] r1_wdata = '0;
    logic [7:0]  r1_len = '0;
    logic        r1_ready, r1_rvalid;
    logic [63:0] r1_rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          e;
        logic [63:0] d;
    } beat_t;

    int          edge_n = 0;
    int          rd_end = -1;
    int          wr_left = 0;
    int          wr_idx = 0;
    logic [63:0] mdl_mem [DEPTH];
    beat_t       exp_q[$];
    logic [63:0] got_q[$];
    int          got_t[$];

    always #5 clk = ~clk;

    mp64_sim_mem_phy #(.DATA_W(64), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst_r), .phy_req(req_r), .phy_addr(addr_r), .phy_wen(wen_r),
        .phy_wdata(wdata_r), .phy_burst_len(len_r), .phy_ready(dut_ready),
        .phy_rdata(dut_rdata), .phy_rvalid(dut_rvalid)
    );

    mp64_sim_mem_phy #(.DATA_W(64), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(r1_rst), .phy_req(r1_req), .phy_addr(r1_addr), .phy_wen(r1_wen),
        .phy_wdata(r1_wdata), .phy_burst_len(r1_len), .phy_ready(r1_ready),
        .phy_rdata(r1_rdata), .phy_rvalid(r1_rvalid)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a read accepted at edge T emits beat k at edge T+LAT+k and frees the port at T+LAT+n.
    task automatic modelEdge();
        int idx, n;
        edge_n++;
        if (rst_r) begin
            rd_end  = -1;
            wr_left = 0;
            exp_q.delete();
        end else if (edge_n <= rd_end) begin
        end else if (wr_left > 0) begin
            if (req_r) begin
                mdl_mem[wr_idx] = wdata_r;
                wr_idx  = (wr_idx + 1) % DEPTH;
                wr_left--;
            end
        end else if (req_r) begin
            idx = int'(addr_r[31:3]) % DEPTH;
            n   = (len_r == 8'd0) ? 1 : int'(len_r);
            if (wen_r) begin
                mdl_mem[idx] = wdata_r;
                wr_idx  = (idx + 1) % DEPTH;
                wr_left = n - 1;
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back('{e: edge_n + LAT + k, d: mdl_mem[(idx + k) % DEPTH]});
                end
                rd_end = edge_n + LAT + n;
            end
        end
    endtask

    task automatic compareModel();
        logic        exp_v;
        logic [63:0] exp_d;
        exp_v = 1'b0;
        exp_d = '0;
        if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
            exp_v = 1'b1;
            exp_d = exp_q[0].d;
            void'(exp_q.pop_front());
        end
        checkOutput("model_ready", 64'(dut_ready), 64'(!rst_r && !(edge_n < rd_end)));
        checkOutput("model_rvalid", 64'(dut_rvalid), 64'(exp_v));
        checkOutput("model_rdata", dut_rdata, exp_d);
    endtask

    task automatic applyStimulus(input logic r, input logic q, input logic [31:0] a,
                                 input logic w, input logic [63:0] d, input logic [7:0] l);
        rst_r   = r;
        req_r   = q;
        addr_r  = a;
        wen_r   = w;
        wdata_r = d;
        len_r   = l;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareModel();
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 8'd0);
    endtask

    task automatic readBurst(input logic [31:0] a, input int n);
        got_q.delete();
        got_t.delete();
        applyStimulus(1'b0, 1'b1, a, 1'b0, 64'h0, 8'(n));
        for (int i = 1; i <= LAT + n + 2; i++) begin
            idleStep();
            if (dut_rvalid) begin
                got_q.push_back(dut_rdata);
                got_t.push_back(i);
            end
        end
        checkOutput("burst_beat_count", 64'(got_q.size()), 64'(n));
        if (got_q.size() == n && n > 0) begin
            checkOutput("burst_first_beat_cycle", 64'(got_t[0]), 64'(LAT));
            checkOutput("burst_no_gaps", 64'(got_t[n-1] - got_t[0]), 64'(n - 1));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int beats;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

        // Reset and first cycle after release.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 8'd0);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 64'h1, 8'd1);
        checkOutput("reset_ready", 64'(dut_ready), 64'd0);
        checkOutput("reset_rvalid", 64'(dut_rvalid), 64'd0);
        checkOutput("reset_rdata", dut_rdata, 64'd0);
        idleStep();
        checkOutput("ready_after_reset", 64'(dut_ready), 64'd1);

        // Single-beat write then read with exact latency.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'd1);
        checkOutput("single_write_idle_ready", 64'(dut_ready), 64'd1);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 64'h0, 8'd1);
        checkOutput("single_read_wait_ready", 64'(dut_ready), 64'd0);
        for (int i = 1; i <= LAT; i++) begin
            idleStep();
            if (i < LAT) checkOutput("single_read_early_rvalid", 64'(dut_rvalid), 64'd0);
        end
        checkOutput("single_read_rvalid", 64'(dut_rvalid), 64'd1);
        checkOutput("single_read_data", dut_rdata, 64'hDEADBEEF_CAFEF00D);
        idleStep();
        checkOutput("single_read_done_rvalid", 64'(dut_rvalid), 64'd0);
        checkOutput("single_read_done_ready", 64'(dut_ready), 64'd1);

        // Four-beat write with a two-cycle stall; address/wen ignored mid-burst.
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 64'd1, 8'd4);
        checkOutput("wr_ready_b1", 64'(dut_ready), 64'd1);
        applyStimulus(1'b0, 1'b1, 32'hFFF0, 1'b0, 64'd2, 8'd9);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'd77, 8'd0);
        checkOutput("wr_ready_stall1", 64'(dut_ready), 64'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'd78, 8'd0);
        checkOutput("wr_ready_stall2", 64'(dut_ready), 64'd1);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 64'd3, 8'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 64'd4, 8'd0);
        checkOutput("wr_ready_after_b4", 64'(dut_ready), 64'd1);
        readBurst(32'h100, 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            checkOutput("burst4_data", got_q[i], 64'(i + 1));

        // Write burst wrapping past the last word.
        applyStimulus(1'b0, 1'b1, 32'((DEPTH - 1) * 8), 1'b1, 64'hAAAA, 8'd3);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 64'hBBBB, 8'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 64'hCCCC, 8'd0);
        readBurst(32'((DEPTH - 1) * 8 + 5), 3);
        if (got_q.size() == 3) begin
            checkOutput("wrap_read_a", got_q[0], 64'hAAAA);
            checkOutput("wrap_read_b", got_q[1], 64'hBBBB);
            checkOutput("wrap_read_c", got_q[2], 64'hCCCC);
        end
        readBurst(32'h0, 1);
        if (got_q.size() == 1) checkOutput("wrap_word0", got_q[0], 64'hBBBB);
        readBurst(32'h8, 1);
        if (got_q.size() == 1) checkOutput("wrap_word1", got_q[0], 64'hCCCC);

        // Zero-length read with phy_req held high throughout.
        beats = 0;
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 64'h0, 8'd0);
        for (int i = 1; i <= LAT + 1; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 64'h0, 8'd0);
            if (dut_rvalid) beats++;
            if (i <= LAT) checkOutput("len0_busy_ready", 64'(dut_ready), 64'd0);
        end
        checkOutput("len0_idle_ready", 64'(dut_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idleStep();
            if (dut_rvalid) beats++;
        end
        checkOutput("len0_beat_count", 64'(beats), 64'd1);

        // Reset during the second beat of an eight-beat read.
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 64'h0, 8'd8);
        for (int i = 1; i <= LAT + 1; i++) idleStep();
        checkOutput("abort_beat1_valid", 64'(dut_rvalid), 64'd1);
        checkOutput("abort_beat1_data", dut_rdata, 64'd2);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 8'd0);
        checkOutput("abort_rvalid", 64'(dut_rvalid), 64'd0);
        checkOutput("abort_ready_in_reset", 64'(dut_ready), 64'd0);
        idleStep();
        checkOutput("abort_ready_after", 64'(dut_ready), 64'd1);
        checkOutput("abort_rvalid_after", 64'(dut_rvalid), 64'd0);
        readBurst(32'h100, 1);
        if (got_q.size() == 1) checkOutput("abort_data_intact", got_q[0], 64'd1);
        readBurst(32'h40, 1);
        if (got_q.size() == 1) checkOutput("abort_data_intact2", got_q[0], 64'hDEADBEEF_CAFEF00D);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, q, w;
            logic [31:0] a;
            logic [7:0]  l;
            r = ($urandom_range(0, 299) == 0);
            q = ($urandom_range(0, 9) < 6);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 3) == 0) ? $urandom() : {22'h0, 7'($urandom_range(0, 127)), 3'($urandom())};
            l = ($urandom_range(0, 199) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            applyStimulus(r, q, a, w, {$urandom(), $urandom()}, l);
        end
        for (int i = 0; i < 300; i++) idleStep();

        // Latency-one build.
        @(negedge clk);
        r1_rst = 1'b0;
        @(negedge clk);
        checkOutput("lat1_ready_after_reset", 64'(r1_ready), 64'd1);
        r1_req = 1'b1; r1_wen = 1'b1; r1_addr = 32'h8; r1_wdata = 64'h12345678_9ABCDEF0; r1_len = 8'd1;
        @(negedge clk);
        r1_wen = 1'b0;
        @(negedge clk);
        checkOutput("lat1_rvalid_after_accept", 64'(r1_rvalid), 64'd0);
        checkOutput("lat1_ready_busy", 64'(r1_ready), 64'd0);
        r1_req = 1'b0;
        @(negedge clk);
        checkOutput("lat1_rvalid", 64'(r1_rvalid), 64'd1);
        checkOutput("lat1_rdata", r1_rdata, 64'h12345678_9ABCDEF0);
        @(negedge clk);
        checkOutput("lat1_rvalid_done", 64'(r1_rvalid), 64'd0);
        checkOutput("lat1_rdata_zero", r1_rdata, 64'd0);
        checkOutput("lat1_ready_done", 64'(r1_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
